// File: rtl/onchip_memory_arbiter.sv
// Two-port arbiter in front of a single-ported on-chip memory with bounded hold per owner.
// Define ONCHIP_ARB_ROUND_ROBIN_EN to break idle ties away from the last owner instead of toward s0.
module onchip_memory_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [10:0] s0_address,
  input  logic [3:0]  s0_byteenable,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [31:0] s0_writedata,
  output logic        s0_waitrequest,
  output logic [31:0] s0_readdata,
  output logic        s0_readdatavalid,

  input  logic [10:0] s1_address,
  input  logic [3:0]  s1_byteenable,
  input  logic        s1_read,
  input  logic        s1_write,
  input  logic [31:0] s1_writedata,
  output logic        s1_waitrequest,
  output logic [31:0] s1_readdata,
  output logic        s1_readdatavalid,

  output logic [10:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       last_owner_q, last_owner_d;
  logic       rdv0_q, rdv0_d;
  logic       rdv1_q, rdv1_d;

  logic req0, req1;
  logic rd0, rd1;
  logic gnt0_raw, gnt1_raw;
  logic gnt0, gnt1;
  logic tie_pick1;

  // Read+write together is a write, so it never produces a read return.
  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;
  assign rd0  = s0_read & ~s0_write;
  assign rd1  = s1_read & ~s1_write;

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
  assign tie_pick1 = ~last_owner_q;
`else
  assign tie_pick1 = 1'b0;
`endif

  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    case (state_q)
      OWN0: begin
        if (req0 && ((hold_cnt_q < HOLD_LAST) || !req1)) begin
          gnt0_raw = 1'b1;
        end else if (req1) begin
          gnt1_raw = 1'b1;
        end
      end
      OWN1: begin
        if (req1 && ((hold_cnt_q < HOLD_LAST) || !req0)) begin
          gnt1_raw = 1'b1;
        end else if (req0) begin
          gnt0_raw = 1'b1;
        end
      end
      default: begin
        if (req0 && req1) begin
          gnt1_raw = tie_pick1;
          gnt0_raw = ~tie_pick1;
        end else begin
          gnt0_raw = req0;
          gnt1_raw = req1;
        end
      end
    endcase
  end

  // Reset only masks what the outside sees; the flops are held by their async reset anyway.
  assign gnt0 = gnt0_raw & reset_n;
  assign gnt1 = gnt1_raw & reset_n;

  always_comb begin
    state_d      = IDLE;
    hold_cnt_d   = 8'd0;
    last_owner_d = last_owner_q;
    if (gnt0_raw) begin
      state_d      = OWN0;
      last_owner_d = 1'b0;
      if (state_q == OWN0) begin
        hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
      end
    end else if (gnt1_raw) begin
      state_d      = OWN1;
      last_owner_d = 1'b1;
      if (state_q == OWN1) begin
        hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
      end
    end
    rdv0_d = gnt0_raw & rd0;
    rdv1_d = gnt1_raw & rd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= 8'd0;
      last_owner_q <= 1'b1;
      rdv0_q       <= 1'b0;
      rdv1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      rdv0_q       <= rdv0_d;
      rdv1_q       <= rdv1_d;
    end
  end

  always_comb begin
    mem_address    = 11'd0;
    mem_byteenable = 4'd0;
    mem_writedata  = 32'd0;
    mem_write      = 1'b0;
    if (gnt0) begin
      mem_address    = s0_address;
      mem_byteenable = s0_byteenable;
      mem_writedata  = s0_writedata;
      mem_write      = s0_write;
    end else if (gnt1) begin
      mem_address    = s1_address;
      mem_byteenable = s1_byteenable;
      mem_writedata  = s1_writedata;
      mem_write      = s1_write;
    end
  end

  assign mem_chipselect   = gnt0 | gnt1;
  assign mem_clken        = 1'b1;

  assign s0_waitrequest   = req0 & ~gnt0;
  assign s1_waitrequest   = req1 & ~gnt1;
  assign s0_readdata      = mem_readdata;
  assign s1_readdata      = mem_readdata;
  assign s0_readdatavalid = rdv0_q;
  assign s1_readdatavalid = rdv1_q;

endmodule
